bp_fe_bp_pred_tracker: RTL and testbench

//  Consumer of the FE branch predictor output. Records every issued prediction
//  (index + predicted direction) in an in-order queue until the backend resolves it.
//  On resolution it compares the actual outcome, pulses a mispredict indication with the branch index,
//  and keeps saturating resolved/mispredict counters for predictor evaluation.

---
 rtl/bp_fe_bp_pkg.sv | 19 +
 rtl/bp_fe_bp_pred_fifo.sv | 60 ++++++
 rtl/bp_fe_bp_pred_tracker.sv | 93 +++++++++
 tb/tb_bp_fe_bp_pred_tracker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_bp_pkg.sv
// Shared types and helpers for the FE branch-prediction tracker.
// Holds the queue entry layout and the saturating counter increment.
package bp_fe_bp_pkg;

    localparam int unsigned bp_fe_idx_width_gp = 9;

    typedef struct packed {
        logic [bp_fe_idx_width_gp-1:0] idx;
        logic                          predict;
    } bp_fe_pred_entry_s;

    // Increment that sticks at the all-ones value of a width_i-bit counter (width_i <= 64).
    function automatic logic [63:0] bp_fe_sat_inc(input logic [63:0] val_i, input int unsigned width_i);
        logic [63:0] max_v;
        max_v = (width_i >= 64) ? '1 : ((64'd1 << width_i) - 64'd1);
        return (val_i >= max_v) ? val_i : val_i + 64'd1;
    endfunction

endpackage

// File: rtl/bp_fe_bp_pred_fifo.sv
// In-order prediction queue: storage array with wrap-bit read/write pointers.
// Flush snaps the read pointer to the write pointer and overrides enq/deq.
module bp_fe_bp_pred_fifo
    import bp_fe_bp_pkg::*;
#(
    parameter int unsigned width_p = 10,
    parameter int unsigned els_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enq_i,
    input  logic [width_p-1:0] data_i,
    input  logic               deq_i,
    input  logic               flush_i,
    output logic [width_p-1:0] data_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int unsigned ptr_w_lp = $clog2(els_p) + 1;

    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [width_p-1:0]  mem_q [els_p];
    logic                enq_ok, deq_ok;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[ptr_w_lp-2:0] == rptr_q[ptr_w_lp-2:0])
                   & (wptr_q[ptr_w_lp-1] != rptr_q[ptr_w_lp-1]);
    assign enq_ok  = enq_i & ~full_o & ~flush_i;
    assign deq_ok  = deq_i & ~empty_o & ~flush_i;
    assign data_o  = mem_q[rptr_q[ptr_w_lp-2:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            rptr_d = wptr_q;
        end else begin
            if (enq_ok) wptr_d = wptr_q + ptr_w_lp'(1);
            if (deq_ok) rptr_d = rptr_q + ptr_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Payload storage carries no reset; pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (enq_ok) mem_q[wptr_q[ptr_w_lp-2:0]] <= data_i;
    end

endmodule

// File: rtl/bp_fe_bp_pred_tracker.sv
// Tracks issued branch predictions until backend resolution, flags mispredicts
// one cycle later and keeps saturating resolved/mispredict statistics.
module bp_fe_bp_pred_tracker
    import bp_fe_bp_pkg::*;
#(
    parameter int unsigned idx_width_p = 9,
    parameter int unsigned els_p       = 8,
    parameter int unsigned ctr_width_p = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   r_v_i,
    input  logic [idx_width_p-1:0] r_idx_i,
    input  logic                   predict_i,
    output logic                   ready_o,
    input  logic                   w_v_i,
    input  logic                   w_taken_i,
    output logic                   w_yumi_o,
    input  logic                   flush_i,
    output logic                   mispredict_v_o,
    output logic [idx_width_p-1:0] mispredict_idx_o,
    output logic [ctr_width_p-1:0] resolved_cnt_o,
    output logic [ctr_width_p-1:0] mispredict_cnt_o,
    output logic                   empty_o,
    output logic                   full_o
);

    typedef struct packed {
        logic [idx_width_p-1:0] idx;
        logic                   predict;
    } entry_t;

    entry_t                 wr_entry, rd_entry;
    logic [idx_width_p:0]   rd_data;
    logic                   enq, mispredict, hit;

    logic                   mv_q, mv_d;
    logic [idx_width_p-1:0] midx_q, midx_d;
    logic [ctr_width_p-1:0] res_q, res_d;
    logic [ctr_width_p-1:0] mis_q, mis_d;

    assign ready_o  = ~full_o;
    assign enq      = r_v_i & ready_o & ~flush_i;
    assign w_yumi_o = w_v_i & ~empty_o & ~flush_i;
    assign wr_entry = '{idx: r_idx_i, predict: predict_i};
    assign rd_entry = entry_t'(rd_data);

    bp_fe_bp_pred_fifo #(
        .width_p (idx_width_p + 1),
        .els_p   (els_p)
    ) fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .enq_i   (enq),
        .data_i  (wr_entry),
        .deq_i   (w_yumi_o),
        .flush_i (flush_i),
        .data_o  (rd_data),
        .empty_o (empty_o),
        .full_o  (full_o)
    );

    always_comb begin
        mispredict = rd_entry.predict ^ w_taken_i;
        hit        = w_yumi_o & mispredict;
        mv_d       = hit;
        midx_d     = hit ? rd_entry.idx : midx_q;
        res_d      = res_q;
        mis_d      = mis_q;
        if (w_yumi_o) res_d = ctr_width_p'(bp_fe_sat_inc(64'(res_q), ctr_width_p));
        if (hit)      mis_d = ctr_width_p'(bp_fe_sat_inc(64'(mis_q), ctr_width_p));
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mv_q   <= 1'b0;
            midx_q <= '0;
            res_q  <= '0;
            mis_q  <= '0;
        end else begin
            mv_q   <= mv_d;
            midx_q <= midx_d;
            res_q  <= res_d;
            mis_q  <= mis_d;
        end
    end

    assign mispredict_v_o   = mv_q;
    assign mispredict_idx_o = midx_q;
    assign resolved_cnt_o   = res_q;
    assign mispredict_cnt_o = mis_q;

endmodule

// File: tb/tb_bp_fe_bp_pred_tracker.sv
// Self-checking bench for bp_fe_bp_pred_tracker: directed table, corner sequences,
// random traffic against a queue-based reference model, and a narrow-counter instance.
module tb_bp_fe_bp_pred_tracker;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        r_v_i, predict_i, w_v_i, w_taken_i, flush_i;
    logic [8:0]  r_idx_i;
    logic        ready_o, w_yumi_o, mispredict_v_o, empty_o, full_o;
    logic [8:0]  mispredict_idx_o;
    logic [31:0] resolved_cnt_o, mispredict_cnt_o;

    logic        s_reset, s_r_v, s_predict, s_w_v, s_taken, s_flush;
    logic [8:0]  s_r_idx;
    logic        s_ready, s_yumi, s_mv, s_empty, s_full;
    logic [8:0]  s_midx;
    logic [3:0]  s_res, s_mis;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bp_fe_bp_pred_tracker dut (
        .clk_i(clk), .reset_i(reset_i), .r_v_i(r_v_i), .r_idx_i(r_idx_i), .predict_i(predict_i),
        .ready_o(ready_o), .w_v_i(w_v_i), .w_taken_i(w_taken_i), .w_yumi_o(w_yumi_o),
        .flush_i(flush_i), .mispredict_v_o(mispredict_v_o), .mispredict_idx_o(mispredict_idx_o),
        .resolved_cnt_o(resolved_cnt_o), .mispredict_cnt_o(mispredict_cnt_o),
        .empty_o(empty_o), .full_o(full_o)
    );

    bp_fe_bp_pred_tracker #(.ctr_width_p(4)) dut_sat (
        .clk_i(clk), .reset_i(s_reset), .r_v_i(s_r_v), .r_idx_i(s_r_idx), .predict_i(s_predict),
        .ready_o(s_ready), .w_v_i(s_w_v), .w_taken_i(s_taken), .w_yumi_o(s_yumi),
        .flush_i(s_flush), .mispredict_v_o(s_mv), .mispredict_idx_o(s_midx),
        .resolved_cnt_o(s_res), .mispredict_cnt_o(s_mis),
        .empty_o(s_empty), .full_o(s_full)
    );

    // Reference model: a plain queue of outstanding predictions plus expected registers.
    typedef struct {
        logic [8:0] idx;
        logic       pred;
    } ment_t;

    ment_t       mq[$];
    logic        m_mv;
    logic [8:0]  m_midx;
    longint      m_res, m_mis;
    localparam int     DEPTH  = 8;
    localparam longint CTRMAX = 64'h0000_0000_FFFF_FFFF;
    logic        yumi_seen;

    typedef struct {
        logic       rv;
        logic [8:0] idx;
        logic       pred;
        logic       wv;
        logic       taken;
        logic       fl;
        logic       exp_yumi;
        logic       exp_mv;
        logic [8:0] exp_midx;
        int         exp_res;
        int         exp_mis;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v >= CTRMAX) ? v : v + 1;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_mv   = 1'b0;
        m_midx = '0;
        m_res  = 0;
        m_mis  = 0;
    endtask

    // One clock: drive inputs at edge+1, check combinational outputs, advance model, check registers.
    task automatic cycle(input logic rv, input logic [8:0] ridx, input logic pr,
                         input logic wv, input logic tk, input logic fl);
        int    occ;
        ment_t e;
        r_v_i = rv; r_idx_i = ridx; predict_i = pr;
        w_v_i = wv; w_taken_i = tk; flush_i = fl;
        #1;
        occ = mq.size();
        chk("ready", ready_o, occ < DEPTH);
        chk("yumi", w_yumi_o, wv && occ > 0 && !fl);
        chk("empty_pre", empty_o, occ == 0);
        chk("full_pre", full_o, occ == DEPTH);
        yumi_seen = w_yumi_o;
        m_mv = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            if (wv && occ > 0) begin
                e = mq.pop_front();
                m_res = sat(m_res);
                if (e.pred != tk) begin
                    m_mis  = sat(m_mis);
                    m_midx = e.idx;
                    m_mv   = 1'b1;
                end
            end
            if (rv && occ < DEPTH) mq.push_back('{ridx, pr});
        end
        @(posedge clk);
        #1;
        chk("mispredict_v", mispredict_v_o, m_mv);
        chk("mispredict_idx", mispredict_idx_o, m_midx);
        chk("resolved_cnt", resolved_cnt_o, m_res);
        chk("mispredict_cnt", mispredict_cnt_o, m_mis);
        chk("empty", empty_o, mq.size() == 0);
        chk("full", full_o, mq.size() == DEPTH);
        r_v_i = 0; w_v_i = 0; flush_i = 0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        #1;
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_yumi", w_yumi_o, 0);
        chk("rst_mv", mispredict_v_o, 0);
        chk("rst_midx", mispredict_idx_o, 0);
        chk("rst_res", resolved_cnt_o, 0);
        chk("rst_mis", mispredict_cnt_o, 0);
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1, 9'h1A3, 1, 0, 0, 0, 0, 0, 9'h000, 0, 0};
        vecs[1] = '{0, 9'h000, 0, 1, 0, 0, 1, 1, 9'h1A3, 1, 1};
        vecs[2] = '{0, 9'h000, 0, 0, 0, 0, 0, 0, 9'h1A3, 1, 1};
        vecs[3] = '{1, 9'h055, 0, 1, 0, 0, 0, 0, 9'h1A3, 1, 1};
        vecs[4] = '{0, 9'h000, 0, 1, 0, 0, 1, 0, 9'h1A3, 2, 1};
        vecs[5] = '{1, 9'h0FF, 0, 0, 0, 0, 0, 0, 9'h1A3, 2, 1};
        vecs[6] = '{0, 9'h000, 0, 1, 1, 0, 1, 1, 9'h0FF, 3, 2};
        vecs[7] = '{1, 9'h0AA, 1, 1, 0, 1, 0, 0, 9'h0FF, 3, 2};
        vecs[8] = '{0, 9'h000, 0, 1, 0, 0, 0, 0, 9'h0FF, 3, 2};

        r_v_i = 0; r_idx_i = 0; predict_i = 0; w_v_i = 0; w_taken_i = 0; flush_i = 0;
        s_r_v = 0; s_r_idx = 0; s_predict = 0; s_w_v = 0; s_taken = 0; s_flush = 0;
        reset_i = 1'b1; s_reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        s_reset = 1'b0;
        do_reset();

        // Directed table: mispredict of 0x1A3, no bypass, correct prediction, flush priority.
        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].rv, vecs[i].idx, vecs[i].pred, vecs[i].wv, vecs[i].taken, vecs[i].fl);
            chk($sformatf("tbl%0d_yumi", i), yumi_seen, vecs[i].exp_yumi);
            chk($sformatf("tbl%0d_mv", i), mispredict_v_o, vecs[i].exp_mv);
            chk($sformatf("tbl%0d_midx", i), mispredict_idx_o, vecs[i].exp_midx);
            chk($sformatf("tbl%0d_res", i), resolved_cnt_o, vecs[i].exp_res);
            chk($sformatf("tbl%0d_mis", i), mispredict_cnt_o, vecs[i].exp_mis);
        end

        // Reset mid-stream with three entries queued and nonzero counters.
        cycle(1, 9'h011, 1, 0, 0, 0);
        cycle(1, 9'h012, 0, 1, 0, 0);
        cycle(1, 9'h013, 0, 0, 0, 0);
        cycle(1, 9'h014, 0, 0, 0, 0);
        chk("pre_rst_mv", mispredict_v_o, 0);
        do_reset();

        // Fill with idx 0..8, ninth dropped; drain with forced mispredicts to expose order.
        for (int i = 0; i < 9; i++) cycle(1, 9'(i), 0, 0, 0, 0);
        chk("fill_full", full_o, 1);
        chk("fill_ready", ready_o, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0, 1, 1, 0);
            chk($sformatf("drain%0d_idx", i), mispredict_idx_o, 9'(i));
        end
        chk("drain_empty", empty_o, 1);

        // Full queue with simultaneous resolve: enqueue still blocked.
        for (int i = 0; i < 8; i++) cycle(1, 9'(9'h100 + i), 1, 0, 0, 0);
        cycle(1, 9'h1FF, 1, 1, 1, 0);
        chk("full_deq_noenq_full", full_o, 0);
        cycle(0, 0, 0, 0, 0, 1);

        // Occupancy 4 with 20 cycles of simultaneous enq/deq: pointers wrap, order kept.
        for (int i = 0; i < 4; i++) cycle(1, 9'($urandom), 1'($urandom), 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, 9'($urandom), 1'($urandom), 1, 1'($urandom), 0);
        chk("sim_occ", mq.size(), 4);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1'($urandom), 0);
        cycle(1, 9'h0C3, 1, 1, 0, 0);
        chk("empty_nobypass", yumi_seen, 0);

        // Flush priority with occupancy 5.
        for (int i = 0; i < 4; i++) cycle(1, 9'($urandom), 1'($urandom), 0, 0, 0);
        cycle(1, 9'h077, 1, 1, 0, 1);
        chk("flush_empty", empty_o, 1);
        chk("flush_yumi", yumi_seen, 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), 9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 19) == 0));
        end

        // Narrow-counter instance: 20 mispredicted resolutions saturate both counters at 4'hF.
        s_r_v = 1; s_r_idx = 9'h033; s_predict = 1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 20; k++) begin
            s_r_v = 1; s_w_v = 1; s_taken = 0; s_predict = 1; s_r_idx = 9'(k);
            @(posedge clk);
            #1;
            chk($sformatf("sat_res%0d", k), s_res, (k > 15) ? 15 : k);
            chk($sformatf("sat_mis%0d", k), s_mis, (k > 15) ? 15 : k);
            chk($sformatf("sat_mv%0d", k), s_mv, 1);
        end
        s_r_v = 0; s_w_v = 0;
        chk("sat_res_final", s_res, 4'hF);
        chk("sat_mis_final", s_mis, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
